// File: rtl/gauss_axis_packer.sv
// Packs the 8-bit filtered pixel stream into 32-bit AXI4-Stream beats (four pixels per beat),
// buffered by a first-word fall-through FIFO whose head sits in the output register.
module gauss_axis_packer #(
   parameter int IMG_W     = 1024,
   parameter int IMG_H     = 1024,
   parameter int LAST_MODE = 0,
   parameter int DEPTH     = 16,
   parameter int AFULL_TH  = 12
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        frame_start,
   input  logic        pix_valid,
   input  logic [7:0]  pix_data,
   output logic [31:0] m_axis_tdata,
   output logic [3:0]  m_axis_tkeep,
   output logic        m_axis_tvalid,
   output logic        m_axis_tlast,
   input  logic        m_axis_tready,
   output logic        fifo_afull,
   output logic        overflow,
   output logic        extra_pix,
   output logic        frame_done
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int LW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int PW = $clog2(DEPTH);
   localparam int NW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

   typedef struct packed {
      logic        fend;
      logic        last;
      logic [3:0]  keep;
      logic [31:0] data;
   } word_t;

   // ---------------- pack stage ----------------
   state_e        state_q, state_d;
   logic [CW-1:0] col_q, col_d, col_e;
   logic [LW-1:0] line_q, line_d, line_e;
   logic [1:0]    bidx_q, bidx_d, bidx_e;
   logic [31:0]   pack_q, pack_d, pack_e;
   logic          wv_q, wv_d;
   word_t         wrd_q, wrd_d;
   logic          extra_q, extra_d;

   logic          accept, last_col, last_line, frame_last, line_end, commit;
   logic [31:0]   lanes;
   logic [3:0]    keep;

   // frame_start restarts the frame in the same cycle, so a coincident pixel lands as pixel 0
   assign col_e  = frame_start ? '0 : col_q;
   assign line_e = frame_start ? '0 : line_q;
   assign bidx_e = frame_start ? '0 : bidx_q;
   assign pack_e = frame_start ? '0 : pack_q;

   assign accept     = pix_valid && (frame_start || state_q == S_RUN);
   assign last_col   = (col_e == CW'(IMG_W - 1));
   assign last_line  = (line_e == LW'(IMG_H - 1));
   assign frame_last = last_col && last_line;
   assign line_end   = (LAST_MODE != 0) && last_col;
   assign commit     = (bidx_e == 2'd3) || frame_last || line_end;

   // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      col_d   = col_e;
      line_d  = line_e;
      bidx_d  = bidx_e;
      pack_d  = pack_e;
      wv_d    = 1'b0;
      wrd_d   = wrd_q;
      extra_d = extra_q && !frame_start;
      lanes   = pack_e;
      lanes[{bidx_e, 3'b000} +: 8] = pix_data;
      case (bidx_e)
         2'd0:    keep = 4'b0001;
         2'd1:    keep = 4'b0011;
         2'd2:    keep = 4'b0111;
         default: keep = 4'b1111;
      endcase

      if (frame_start) state_d = S_RUN;
      if (pix_valid && !accept) extra_d = 1'b1;

      if (accept) begin
         col_d = last_col ? '0 : col_e + CW'(1);
         if (last_col) line_d = last_line ? '0 : line_e + LW'(1);
         if (commit) begin
            wv_d   = 1'b1;
            wrd_d  = '{fend: frame_last, last: frame_last || line_end, keep: keep, data: lanes};
            bidx_d = '0;
            pack_d = '0;
         end else begin
            bidx_d = bidx_e + 2'd1;
            pack_d = lanes;
         end
         if (frame_last) state_d = S_DONE;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         col_q   <= '0;
         line_q  <= '0;
         bidx_q  <= '0;
         pack_q  <= '0;
         wv_q    <= 1'b0;
         wrd_q   <= '0;
         extra_q <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         line_q  <= line_d;
         bidx_q  <= bidx_d;
         pack_q  <= pack_d;
         wv_q    <= wv_d;
         wrd_q   <= wrd_d;
         extra_q <= extra_d;
      end
   end

   // ---------------- FIFO: storage plus output register, DEPTH words in total ----------------
   word_t         mem [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [NW-1:0] cnt_q, cnt_d;
   word_t         out_q, out_d;
   logic          ov_q, ov_d;
   logic          afull_q, ovf_q, ovf_d;
   logic          pop, push_ok, mem_empty, load, bypass, mem_wr, mem_rd;

   assign pop       = ov_q && m_axis_tready;
   assign push_ok   = wv_q && ((cnt_q != NW'(DEPTH)) || pop);
   assign mem_empty = (cnt_q == NW'(ov_q));
   assign load      = !ov_q || pop;
   assign bypass    = load && mem_empty && push_ok;
   assign mem_wr    = push_ok && !bypass;
   assign mem_rd    = load && !mem_empty;

   always_comb begin
      ov_d  = ov_q;
      out_d = out_q;
      if (mem_rd) begin
         out_d = mem[rd_ptr_q];
         ov_d  = 1'b1;
      end else if (bypass) begin
         out_d = wrd_q;
         ov_d  = 1'b1;
      end else if (load) begin
         ov_d  = 1'b0;
      end
      cnt_d = cnt_q + NW'(push_ok) - NW'(pop);
      ovf_d = (ovf_q && !frame_start) || (wv_q && !push_ok);
   end

   // NOTE: the storage array carries no reset; occupancy and pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (mem_wr) mem[wr_ptr_q] <= wrd_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         out_q    <= '0;
         ov_q     <= 1'b0;
         afull_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         if (mem_wr) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (mem_rd) rd_ptr_q <= rd_ptr_q + PW'(1);
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         ov_q    <= ov_d;
         afull_q <= (cnt_d >= NW'(AFULL_TH));
         ovf_q   <= ovf_d;
      end
   end

   assign m_axis_tdata  = out_q.data;
   assign m_axis_tkeep  = out_q.keep;
   assign m_axis_tlast  = out_q.last;
   assign m_axis_tvalid = ov_q;
   assign fifo_afull    = afull_q;
   assign overflow      = ovf_q;
   assign extra_pix     = extra_q;
   assign frame_done    = pop && out_q.fend;

endmodule

// File: tb/tb_gauss_axis_packer.sv
// Directed bench for gauss_axis_packer: four instances cover frame/line tlast, backpressure and overflow.
`timescale 1ns/1ps
module tb_gauss_axis_packer;

   typedef struct packed {
      logic [1:0]  inst;
      logic        fd;
      logic        last;
      logic [3:0]  keep;
      logic [31:0] data;
   } beat_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [3:0] rst_n, fs, pv, rdy, tv, tl, af, ovf, xp, fd;
   logic [7:0]  pd [4];
   logic [31:0] td [4];
   logic [3:0]  tk [4];

   int    errors = 0;
   int    checks = 0;
   beat_t bq[$];
   int    fd_cnt [4];

   gauss_axis_packer #(.IMG_W(8), .IMG_H(2), .LAST_MODE(0), .DEPTH(16), .AFULL_TH(12)) u0 (
      .clk(clk), .rst_n(rst_n[0]), .frame_start(fs[0]), .pix_valid(pv[0]), .pix_data(pd[0]),
      .m_axis_tdata(td[0]), .m_axis_tkeep(tk[0]), .m_axis_tvalid(tv[0]), .m_axis_tlast(tl[0]),
      .m_axis_tready(rdy[0]), .fifo_afull(af[0]), .overflow(ovf[0]), .extra_pix(xp[0]), .frame_done(fd[0]));

   gauss_axis_packer #(.IMG_W(6), .IMG_H(2), .LAST_MODE(1), .DEPTH(16), .AFULL_TH(12)) u1 (
      .clk(clk), .rst_n(rst_n[1]), .frame_start(fs[1]), .pix_valid(pv[1]), .pix_data(pd[1]),
      .m_axis_tdata(td[1]), .m_axis_tkeep(tk[1]), .m_axis_tvalid(tv[1]), .m_axis_tlast(tl[1]),
      .m_axis_tready(rdy[1]), .fifo_afull(af[1]), .overflow(ovf[1]), .extra_pix(xp[1]), .frame_done(fd[1]));

   gauss_axis_packer #(.IMG_W(8), .IMG_H(8), .LAST_MODE(0), .DEPTH(16), .AFULL_TH(12)) u2 (
      .clk(clk), .rst_n(rst_n[2]), .frame_start(fs[2]), .pix_valid(pv[2]), .pix_data(pd[2]),
      .m_axis_tdata(td[2]), .m_axis_tkeep(tk[2]), .m_axis_tvalid(tv[2]), .m_axis_tlast(tl[2]),
      .m_axis_tready(rdy[2]), .fifo_afull(af[2]), .overflow(ovf[2]), .extra_pix(xp[2]), .frame_done(fd[2]));

   gauss_axis_packer #(.IMG_W(8), .IMG_H(8), .LAST_MODE(0), .DEPTH(4), .AFULL_TH(3)) u3 (
      .clk(clk), .rst_n(rst_n[3]), .frame_start(fs[3]), .pix_valid(pv[3]), .pix_data(pd[3]),
      .m_axis_tdata(td[3]), .m_axis_tkeep(tk[3]), .m_axis_tvalid(tv[3]), .m_axis_tlast(tl[3]),
      .m_axis_tready(rdy[3]), .fifo_afull(af[3]), .overflow(ovf[3]), .extra_pix(xp[3]), .frame_done(fd[3]));

   // Inputs change 1ns after posedge; the negedge sees exactly what the next posedge will see.
   always @(negedge clk) begin : monitor
      beat_t b;
      for (int k = 0; k < 4; k++) begin
         if (tv[k] && rdy[k]) begin
            b = {2'(k), fd[k], tl[k], tk[k], td[k]};
            bq.push_back(b);
         end
         if (fd[k]) fd_cnt[k]++;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int k, input logic f, input logic v, input logic [7:0] d);
      fs[k] = f;
      pv[k] = v;
      pd[k] = d;
   endtask

   task automatic test_reset;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if ({tv[k], tl[k], af[k], ovf[k], xp[k], fd[k], tk[k], td[k]} !== '0) begin
            errors++;
            $display("FAIL reset_outputs inst%0d: got tv=%b tdata=%h tkeep=%h flags=%b required all 0",
                     k, tv[k], td[k], tk[k], {tl[k], af[k], ovf[k], xp[k], fd[k]});
         end
      end
   endtask

   task automatic test_extra_pix;
      bq.delete();
      rdy[0] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(0, 1'b0, 1'b1, 8'(8'hE0 + i));
         tick;
      end
      drive(0, 1'b0, 1'b0, 8'h00);
      repeat (4) tick;
      @(negedge clk);
      checks++;
      if (bq.size() !== 0) begin
         errors++;
         $display("FAIL idle_no_beats: got %0d beats required 0", bq.size());
      end
      checks++;
      if (xp[0] !== 1'b1) begin
         errors++;
         $display("FAIL idle_extra_pix: got %b required 1", xp[0]);
      end
      tick;
   endtask

   task automatic test_frame_mode0;
      beat_t e;
      bq.delete();
      fd_cnt[0] = 0;
      drive(0, 1'b1, 1'b0, 8'h00);
      tick;
      for (int i = 1; i <= 16; i++) begin
         drive(0, 1'b0, 1'b1, 8'(i));
         @(negedge clk);
         if (i == 1) begin
            checks++;
            if (xp[0] !== 1'b0) begin
               errors++;
               $display("FAIL fs_clears_extra_pix: got %b required 0", xp[0]);
            end
         end
         if (i == 5) begin
            checks++;
            if (tv[0] !== 1'b0) begin
               errors++;
               $display("FAIL latency_early: tvalid got %b required 0 one cycle after commit", tv[0]);
            end
         end
         if (i == 6) begin
            checks++;
            if (tv[0] !== 1'b1) begin
               errors++;
               $display("FAIL latency_two: tvalid got %b required 1 two cycles after commit", tv[0]);
            end
         end
         tick;
      end
      drive(0, 1'b0, 1'b0, 8'h00);
      repeat (8) tick;
      @(negedge clk);
      checks++;
      if (bq.size() !== 4) begin
         errors++;
         $display("FAIL mode0_beat_count: got %0d required 4", bq.size());
      end
      for (int n = 0; n < 4 && n < bq.size(); n++) begin
         e = '0;
         e.fd = (n == 3);
         e.last = (n == 3);
         e.keep = 4'hF;
         for (int j = 0; j < 4; j++) e.data[8*j +: 8] = 8'(4*n + 1 + j);
         checks++;
         if (bq[n] !== e) begin
            errors++;
            $display("FAIL mode0_beat%0d: got %h required %h", n, bq[n], e);
         end
      end
      checks++;
      if (fd_cnt[0] !== 1) begin
         errors++;
         $display("FAIL mode0_frame_done: got %0d pulses required 1", fd_cnt[0]);
      end
      checks++;
      if (xp[0] !== 1'b0) begin
         errors++;
         $display("FAIL mode0_extra_before: got %b required 0", xp[0]);
      end
      tick;
      drive(0, 1'b0, 1'b1, 8'h55);
      tick;
      drive(0, 1'b0, 1'b0, 8'h00);
      repeat (6) tick;
      @(negedge clk);
      checks++;
      if (xp[0] !== 1'b1 || bq.size() !== 4) begin
         errors++;
         $display("FAIL done_extra_pix: got extra=%b beats=%0d required extra=1 beats=4", xp[0], bq.size());
      end
      tick;
   endtask

   task automatic test_line_mode;
      beat_t e [4];
      bq.delete();
      fd_cnt[1] = 0;
      rdy[1] = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         drive(1, (i == 1), 1'b1, 8'(i));
         tick;
      end
      drive(1, 1'b0, 1'b0, 8'h00);
      repeat (8) tick;
      @(negedge clk);
      e[0] = {2'd1, 1'b0, 1'b0, 4'hF, 32'h04030201};
      e[1] = {2'd1, 1'b0, 1'b1, 4'h3, 32'h00000605};
      e[2] = {2'd1, 1'b0, 1'b0, 4'hF, 32'h0A090807};
      e[3] = {2'd1, 1'b1, 1'b1, 4'h3, 32'h00000C0B};
      checks++;
      if (bq.size() !== 4) begin
         errors++;
         $display("FAIL line_beat_count: got %0d required 4", bq.size());
      end
      for (int n = 0; n < 4 && n < bq.size(); n++) begin
         checks++;
         if (bq[n] !== e[n]) begin
            errors++;
            $display("FAIL line_beat%0d: got %h required %h", n, bq[n], e[n]);
         end
      end
      checks++;
      if (fd_cnt[1] !== 1) begin
         errors++;
         $display("FAIL line_frame_done: got %0d pulses required 1", fd_cnt[1]);
      end
      tick;
   endtask

   task automatic test_backpressure;
      beat_t       e;
      logic        hold;
      logic [36:0] held;
      bq.delete();
      fd_cnt[2] = 0;
      rdy[2] = 1'b0;
      drive(2, 1'b1, 1'b0, 8'h00);
      tick;
      for (int i = 1; i <= 64; i++) begin
         drive(2, 1'b0, 1'b1, 8'(i));
         @(negedge clk);
         if (i == 49) begin
            checks++;
            if (af[2] !== 1'b0) begin
               errors++;
               $display("FAIL afull_early: got %b required 0 at 11 words", af[2]);
            end
         end
         if (i == 50) begin
            checks++;
            if (af[2] !== 1'b1) begin
               errors++;
               $display("FAIL afull_rise: got %b required 1 at 12 words", af[2]);
            end
         end
         tick;
      end
      drive(2, 1'b0, 1'b0, 8'h00);
      repeat (3) tick;
      @(negedge clk);
      checks++;
      if (ovf[2] !== 1'b0 || af[2] !== 1'b1) begin
         errors++;
         $display("FAIL bp_full16: got overflow=%b afull=%b required 0 and 1", ovf[2], af[2]);
      end
      tick;
      hold = 1'b0;
      held = '0;
      for (int c = 0; c < 200 && bq.size() < 16; c++) begin
         rdy[2] = (c % 2 == 1);
         @(negedge clk);
         if (hold) begin
            checks++;
            if (tv[2] !== 1'b1 || {tl[2], tk[2], td[2]} !== held) begin
               errors++;
               $display("FAIL bp_stable: got tv=%b %h required tv=1 %h", tv[2], {tl[2], tk[2], td[2]}, held);
            end
         end
         hold = tv[2] && !rdy[2];
         held = {tl[2], tk[2], td[2]};
         tick;
      end
      rdy[2] = 1'b1;
      checks++;
      if (bq.size() !== 16) begin
         errors++;
         $display("FAIL bp_beat_count: got %0d required 16", bq.size());
      end
      for (int n = 0; n < 16 && n < bq.size(); n++) begin
         e = '0;
         e.inst = 2'd2;
         e.fd = (n == 15);
         e.last = (n == 15);
         e.keep = 4'hF;
         for (int j = 0; j < 4; j++) e.data[8*j +: 8] = 8'(4*n + 1 + j);
         checks++;
         if (bq[n] !== e) begin
            errors++;
            $display("FAIL bp_beat%0d: got %h required %h", n, bq[n], e);
         end
      end
      checks++;
      if (fd_cnt[2] !== 1) begin
         errors++;
         $display("FAIL bp_frame_done: got %0d pulses required 1", fd_cnt[2]);
      end
   endtask

   task automatic test_overflow;
      beat_t e;
      bq.delete();
      rdy[3] = 1'b0;
      drive(3, 1'b1, 1'b0, 8'h00);
      tick;
      for (int i = 1; i <= 20; i++) begin
         drive(3, 1'b0, 1'b1, 8'(i));
         @(negedge clk);
         if (i == 20) begin
            checks++;
            if (ovf[3] !== 1'b0) begin
               errors++;
               $display("FAIL ovf_early: got %b required 0 with 4 words", ovf[3]);
            end
         end
         tick;
      end
      drive(3, 1'b0, 1'b0, 8'h00);
      tick;
      @(negedge clk);
      checks++;
      if (ovf[3] !== 1'b1) begin
         errors++;
         $display("FAIL ovf_set: got %b required 1 after 5th word", ovf[3]);
      end
      tick;
      rdy[3] = 1'b1;
      repeat (12) tick;
      @(negedge clk);
      checks++;
      if (bq.size() !== 4) begin
         errors++;
         $display("FAIL ovf_drain_count: got %0d required 4", bq.size());
      end
      for (int n = 0; n < 4 && n < bq.size(); n++) begin
         e = '0;
         e.inst = 2'd3;
         e.keep = 4'hF;
         for (int j = 0; j < 4; j++) e.data[8*j +: 8] = 8'(4*n + 1 + j);
         checks++;
         if (bq[n] !== e) begin
            errors++;
            $display("FAIL ovf_beat%0d: got %h required %h", n, bq[n], e);
         end
      end
      tick;
      drive(3, 1'b1, 1'b0, 8'h00);
      tick;
      drive(3, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      checks++;
      if (ovf[3] !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear: got %b required 0 after frame_start", ovf[3]);
      end
      tick;
   endtask

   task automatic test_abort;
      beat_t e;
      bq.delete();
      fd_cnt[0] = 0;
      rdy[0] = 1'b1;
      drive(0, 1'b1, 1'b0, 8'h00);
      tick;
      for (int i = 1; i <= 6; i++) begin
         drive(0, 1'b0, 1'b1, 8'(i));
         tick;
      end
      drive(0, 1'b1, 1'b1, 8'hA1);
      tick;
      for (int i = 8'hA2; i <= 8'hB0; i++) begin
         drive(0, 1'b0, 1'b1, 8'(i));
         tick;
      end
      drive(0, 1'b0, 1'b0, 8'h00);
      repeat (8) tick;
      @(negedge clk);
      checks++;
      if (bq.size() !== 5) begin
         errors++;
         $display("FAIL abort_beat_count: got %0d required 5", bq.size());
      end
      for (int n = 0; n < 5 && n < bq.size(); n++) begin
         e = '0;
         e.keep = 4'hF;
         if (n == 0) e.data = 32'h04030201;
         else for (int j = 0; j < 4; j++) e.data[8*j +: 8] = 8'(8'hA1 + 4*(n-1) + j);
         e.fd = (n == 4);
         e.last = (n == 4);
         checks++;
         if (bq[n] !== e) begin
            errors++;
            $display("FAIL abort_beat%0d: got %h required %h", n, bq[n], e);
         end
      end
      checks++;
      if (fd_cnt[0] !== 1) begin
         errors++;
         $display("FAIL abort_frame_done: got %0d pulses required 1", fd_cnt[0]);
      end
      tick;
   endtask

   task automatic test_reset_midbeat;
      bq.delete();
      rdy[0] = 1'b0;
      drive(0, 1'b1, 1'b0, 8'h00);
      tick;
      for (int i = 1; i <= 8; i++) begin
         drive(0, 1'b0, 1'b1, 8'(8'h30 + i));
         tick;
      end
      drive(0, 1'b0, 1'b0, 8'h00);
      repeat (3) tick;
      @(negedge clk);
      checks++;
      if (tv[0] !== 1'b1 || td[0] !== 32'h34333231) begin
         errors++;
         $display("FAIL pre_reset_head: got tv=%b tdata=%h required tv=1 tdata=34333231", tv[0], td[0]);
      end
      tick;
      rst_n[0] = 1'b0;
      tick;
      rst_n[0] = 1'b1;
      @(negedge clk);
      checks++;
      if ({tv[0], tl[0], af[0], ovf[0], xp[0], fd[0], tk[0], td[0]} !== '0) begin
         errors++;
         $display("FAIL midbeat_reset: got tv=%b tdata=%h tkeep=%h flags=%b required all 0",
                  tv[0], td[0], tk[0], {tl[0], af[0], ovf[0], xp[0], fd[0]});
      end
      tick;
      rdy[0] = 1'b1;
      repeat (6) tick;
      @(negedge clk);
      checks++;
      if (bq.size() !== 0 || tv[0] !== 1'b0) begin
         errors++;
         $display("FAIL reset_fifo_empty: got beats=%0d tv=%b required 0 and 0", bq.size(), tv[0]);
      end
      tick;
   endtask

   initial begin
      rst_n = '0;
      fs    = '0;
      pv    = '0;
      rdy   = '0;
      for (int k = 0; k < 4; k++) begin
         pd[k] = '0;
         fd_cnt[k] = 0;
      end
      tick;
      tick;
      test_reset;
      tick;
      rst_n = '1;
      tick;
      test_extra_pix;
      test_frame_mode0;
      test_line_mode;
      test_backpressure;
      test_overflow;
      test_abort;
      test_reset_midbeat;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
